// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit ctrl layout, ALU mode encodings, grid size,
// host-injector FSM states and the ctrl packing helper.
package noc_pkg;

    localparam int unsigned CTRL_W        = 16;
    localparam int unsigned CTRL_RESP_BIT = 8;
    localparam int unsigned CTRL_X_LSB    = 6;
    localparam int unsigned CTRL_Y_LSB    = 4;
    localparam int unsigned CTRL_MODE_LSB = 0;

    localparam int unsigned GRID_DIM  = 3;
    localparam logic [1:0]  COORD_MAX = 2'(GRID_DIM - 1);

    typedef enum logic [3:0] {
        MODE_ADD = 4'd0,
        MODE_SUB = 4'd1,
        MODE_MUL = 4'd2,
        MODE_AND = 4'd3,
        MODE_OR  = 4'd4,
        MODE_XOR = 4'd5,
        MODE_SHL = 4'd6,
        MODE_SHR = 4'd7,
        MODE_CMP = 4'd8
    } noc_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INJECT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } noc_state_e;

    function automatic logic [CTRL_W-1:0] pack_ctrl(input logic       resp,
                                                    input logic [1:0] dst_x,
                                                    input logic [1:0] dst_y,
                                                    input logic [3:0] mode);
        logic [CTRL_W-1:0] ctrl;
        ctrl                          = 16'd0;
        ctrl[CTRL_RESP_BIT]           = resp;
        ctrl[CTRL_X_LSB +: 2]         = dst_x;
        ctrl[CTRL_Y_LSB +: 2]         = dst_y;
        ctrl[CTRL_MODE_LSB +: 4]      = mode;
        return ctrl;
    endfunction

endpackage

// File: rtl/noc_wait_timer.sv
// Response wait counter: cleared on entry to WAIT, counts idle WAIT cycles and
// flags the last permitted cycle so the FSM can give up.
module noc_wait_timer
    import noc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_r;

    // Wait counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 16'd0;
        end else if (clear) begin
            cnt_r <= 16'd0;
        end else if (enable) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // This idle WAIT cycle would bring the count to TIMEOUT_CYCLES
    assign expired = enable && (cnt_r == LAST_COUNT);

endmodule

// File: rtl/noc_host_injector.sv
// Host-port injector: turns one calculator request into one flit for tile (0,0)
// and returns the response or an error. Optional stats: NOC_HOST_STATS_EN.
module noc_host_injector
    import noc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [3:0]  req_mode,
    input  logic [1:0]  req_dst_x,
    input  logic [1:0]  req_dst_y,
    output logic [63:0] host_in_a,
    output logic [63:0] host_in_b,
    output logic [15:0] host_in_ctrl,
    output logic        host_in_valid,
    input  logic [63:0] host_out_a,
    input  logic        host_out_valid,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_err
`ifdef NOC_HOST_STATS_EN
    ,
    output logic [31:0] stat_req_cnt,
    output logic [31:0] stat_to_cnt
`endif
);

    noc_state_e  state_r, next_state_s;
    logic        accept_s, bad_dst_s, capture_s, timeout_s;
    logic        timer_clear_s, timer_en_s, timer_expired_s;

    // Flit registers double as the registered request; they only live for INJECT
    logic [63:0] host_in_a_r, host_in_b_r;
    logic [15:0] host_in_ctrl_r;
    logic        host_in_valid_r;
    logic [63:0] rsp_data_r;
    logic        rsp_valid_r, rsp_err_r;

    assign req_ready = (state_r == ST_IDLE) && !rst;
    assign accept_s  = req_valid && req_ready;
    assign bad_dst_s = (req_dst_x > COORD_MAX) || (req_dst_y > COORD_MAX);

    assign capture_s = ((state_r == ST_INJECT) || (state_r == ST_WAIT)) && host_out_valid;
    assign timeout_s = (state_r == ST_WAIT) && timer_expired_s;

    assign timer_clear_s = (state_r == ST_INJECT);
    assign timer_en_s    = (state_r == ST_WAIT) && !host_out_valid;

    noc_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear_s),
        .enable (timer_en_s),
        .expired(timer_expired_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a response always wins over a coincident timeout
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = bad_dst_s ? ST_RESP : ST_INJECT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_INJECT: begin
                if (capture_s) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (capture_s || timeout_s) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Flit registers: loaded on a good acceptance, zero in every other cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            host_in_valid_r <= 1'b0;
            host_in_a_r     <= 64'd0;
            host_in_b_r     <= 64'd0;
            host_in_ctrl_r  <= 16'd0;
        end else if (accept_s && !bad_dst_s) begin
            host_in_valid_r <= 1'b1;
            host_in_a_r     <= req_a;
            host_in_b_r     <= req_b;
            host_in_ctrl_r  <= pack_ctrl(1'b0, req_dst_x, req_dst_y, req_mode);
        end else begin
            host_in_valid_r <= 1'b0;
            host_in_a_r     <= 64'd0;
            host_in_b_r     <= 64'd0;
            host_in_ctrl_r  <= 16'd0;
        end
    end

    // Response registers: set on entry to RESP, held until the handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 64'd0;
            rsp_err_r   <= 1'b0;
        end else if (accept_s && bad_dst_s) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= 64'd0;
            rsp_err_r   <= 1'b1;
        end else if (capture_s) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= host_out_a;
            rsp_err_r   <= 1'b0;
        end else if (timeout_s) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= 64'd0;
            rsp_err_r   <= 1'b1;
        end else if ((state_r == ST_RESP) && rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 64'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
            rsp_data_r  <= rsp_data_r;
            rsp_err_r   <= rsp_err_r;
        end
    end

    assign host_in_valid = host_in_valid_r;
    assign host_in_a     = host_in_a_r;
    assign host_in_b     = host_in_b_r;
    assign host_in_ctrl  = host_in_ctrl_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_data      = rsp_data_r;
    assign rsp_err       = rsp_err_r;

`ifdef NOC_HOST_STATS_EN
    logic [31:0] stat_req_cnt_r, stat_to_cnt_r;

    // Statistics counters; error count covers timeouts and bad destinations
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_req_cnt_r <= 32'd0;
            stat_to_cnt_r  <= 32'd0;
        end else begin
            if (accept_s) begin
                stat_req_cnt_r <= stat_req_cnt_r + 32'd1;
            end
            if ((accept_s && bad_dst_s) || timeout_s) begin
                stat_to_cnt_r <= stat_to_cnt_r + 32'd1;
            end
        end
    end

    assign stat_req_cnt = stat_req_cnt_r;
    assign stat_to_cnt  = stat_to_cnt_r;
`endif

endmodule

// File: tb/tb_noc_host_injector.sv
// Directed table-driven bench for noc_host_injector (TIMEOUT_CYCLES=4), plus
// hand sequences for back-pressure, stray responses and mid-flight reset.
module tb_noc_host_injector;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [63:0] req_a, req_b;
    logic [3:0]  req_mode;
    logic [1:0]  req_dst_x, req_dst_y;
    logic [63:0] host_in_a, host_in_b;
    logic [15:0] host_in_ctrl;
    logic        host_in_valid;
    logic [63:0] host_out_a;
    logic        host_out_valid;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_err;
`ifdef NOC_HOST_STATS_EN
    logic [31:0] stat_req_cnt, stat_to_cnt;
`endif

    int checks = 0;
    int errors = 0;

    noc_host_injector #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_mode      (req_mode),
        .req_dst_x     (req_dst_x),
        .req_dst_y     (req_dst_y),
        .host_in_a     (host_in_a),
        .host_in_b     (host_in_b),
        .host_in_ctrl  (host_in_ctrl),
        .host_in_valid (host_in_valid),
        .host_out_a    (host_out_a),
        .host_out_valid(host_out_valid),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err)
`ifdef NOC_HOST_STATS_EN
        ,
        .stat_req_cnt  (stat_req_cnt),
        .stat_to_cnt   (stat_to_cnt)
`endif
    );

    always #5 clk = ~clk;

    // dly: cycle index after acceptance-1 when host_out_valid is driven (0 = INJECT
    // cycle, 99 = never); rsp_cyc: cycle after acceptance in which rsp_valid rises
    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  mode;
        logic [1:0]  x;
        logic [1:0]  y;
        int          dly;
        logic [63:0] val;
        logic        inject;
        logic [15:0] ctrl;
        int          rsp_cyc;
        logic [63:0] data;
        logic        err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid      = 1'b0;
        req_a          = 64'd0;
        req_b          = 64'd0;
        req_mode       = 4'd0;
        req_dst_x      = 2'd0;
        req_dst_y      = 2'd0;
        host_out_valid = 1'b0;
        host_out_a     = 64'd0;
        rsp_ready      = 1'b0;
    endtask

    // Present a request at a negedge; returns just after the accepting posedge
    task automatic send_req(input logic [63:0] a, input logic [63:0] b, input logic [3:0] mode,
                            input logic [1:0] x, input logic [1:0] y);
        @(negedge clk);
        req_a     = a;
        req_b     = b;
        req_mode  = mode;
        req_dst_x = x;
        req_dst_y = y;
        req_valid = 1'b1;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = 64'hBAD0_BAD0_BAD0_BAD0;
        req_b     = 64'hBAD1_BAD1_BAD1_BAD1;
    endtask

    task automatic run_vec(input vec_t v);
        send_req(v.a, v.b, v.mode, v.x, v.y);
        for (int cyc = 1; cyc <= v.rsp_cyc; cyc++) begin
            host_out_valid = (v.dly == cyc - 1);
            host_out_a     = (v.dly == cyc - 1) ? v.val : 64'hEEEE_0000_EEEE_0000;
            @(negedge clk);
            chk("host_in_valid", 64'(host_in_valid), 64'((cyc == 1) && v.inject));
            if ((cyc == 1) && v.inject) begin
                chk("host_in_ctrl", 64'(host_in_ctrl), 64'(v.ctrl));
                chk("host_in_a", host_in_a, v.a);
                chk("host_in_b", host_in_b, v.b);
            end else begin
                chk("host_in_zero", {host_in_a ^ host_in_b, 48'd0} | 64'(host_in_ctrl), 64'd0);
            end
            chk("rsp_valid", 64'(rsp_valid), 64'(cyc == v.rsp_cyc));
            if (cyc == v.rsp_cyc) begin
                chk("rsp_data", rsp_data, v.data);
                chk("rsp_err", 64'(rsp_err), 64'(v.err));
                rsp_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            host_out_valid = 1'b0;
        end
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("rsp_valid_after_hs", 64'(rsp_valid), 64'd0);
        chk("req_ready_after_hs", 64'(req_ready), 64'd1);
    endtask

    initial begin
        //              a       b      mode  x     y     dly val                     inj   ctrl      cyc data                    err
        vecs[0] = '{64'd7, 64'd5, 4'd0, 2'd2, 2'd1, 3,  64'd12,                 1'b1, 16'h0090, 5, 64'd12,                 1'b0};
        vecs[1] = '{64'd6, 64'd7, 4'd2, 2'd0, 2'd0, 0,  64'd42,                 1'b1, 16'h0002, 2, 64'd42,                 1'b0};
        vecs[2] = '{64'd1, 64'd2, 4'd0, 2'd3, 2'd0, 99, 64'd0,                  1'b0, 16'h0000, 1, 64'd0,                  1'b1};
        vecs[3] = '{64'd3, 64'd4, 4'd8, 2'd1, 2'd3, 99, 64'd0,                  1'b0, 16'h0000, 1, 64'd0,                  1'b1};
        vecs[4] = '{64'd9, 64'd9, 4'd5, 2'd1, 2'd2, 99, 64'd0,                  1'b1, 16'h0065, 6, 64'd0,                  1'b1};
        vecs[5] = '{64'hA, 64'hB, 4'd8, 2'd2, 2'd2, 4,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 16'h00A8, 6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[6] = '{64'hC, 64'hD, 4'd3, 2'd0, 2'd2, 1,  64'h1234_5678_9ABC_DEF0, 1'b1, 16'h0023, 3, 64'h1234_5678_9ABC_DEF0, 1'b0};

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp", {rsp_data[62:0], rsp_valid} | 64'(rsp_err), 64'd0);
        chk("rst_host_in", host_in_a | host_in_b | 64'(host_in_ctrl) | 64'(host_in_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("req_ready_after_rst", 64'(req_ready), 64'd1);

        // Reset while waiting, then a late response must be ignored
        send_req(64'd100, 64'd200, 4'd1, 2'd2, 2'd0);
        @(negedge clk);
        chk("mid_inject", 64'(host_in_valid), 64'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_release_ready", 64'(req_ready), 64'd1);
        host_out_valid = 1'b1;
        host_out_a     = 64'd77;
        repeat (3) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("stray_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("stray_req_ready", 64'(req_ready), 64'd1);
        end
        host_out_valid = 1'b0;

        // Stray response in IDLE right before the table
        @(negedge clk);
        host_out_valid = 1'b1;
        host_out_a     = 64'd55;
        @(posedge clk);
        #1;
        host_out_valid = 1'b0;
        @(negedge clk);
        chk("idle_stray", 64'(rsp_valid), 64'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-pressure: response held for 10 cycles with stray host_out_valid
        send_req(64'd1, 64'd1, 4'd1, 2'd1, 2'd1);
        host_out_valid = 1'b1;
        host_out_a     = 64'd99;
        @(posedge clk);
        #1;
        host_out_a = 64'd1234;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rsp_data", rsp_data, 64'd99);
            chk("hold_rsp_err", 64'(rsp_err), 64'd0);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        host_out_valid = 1'b0;
        rsp_ready      = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("hold_release", 64'(rsp_valid), 64'd0);
        chk("hold_req_ready_back", 64'(req_ready), 64'd1);

`ifdef NOC_HOST_STATS_EN
        chk("stat_req_cnt", 64'(stat_req_cnt), 64'd8);
        chk("stat_to_cnt", 64'(stat_to_cnt), 64'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
